// File: rtl/card_picker.sv
// Random card dealer: free-running Galois LFSR proposes candidates, a used mask
// rejects dealt cards, and a bounded search falls back to a lowest-free-card scan.
module card_picker #(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          MAX_TRIES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        draw_req,
    input  logic        seed_load,
    input  logic [15:0] seed_in,
    input  logic        deck_clear,
    output logic [5:0]  card_idx,
    output logic        card_valid,
    output logic        busy,
    output logic        deck_empty,
    output logic [5:0]  cards_left,
    output logic [53:0] used_mask,
    output logic        draw_err,
    output logic [1:0]  state_dbg
);

    // Handshake: draw_req/seed_load/deck_clear act only while busy=0; each
    // accepted draw yields exactly one single-cycle card_valid pulse.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    state_t           state, state_nxt;
    logic [15:0]      lfsr, lfsr_nxt, lfsr_step;
    logic [TRY_W-1:0] tries, tries_nxt;
    logic [53:0]      mask_nxt;
    logic [5:0]       left_nxt, idx_nxt;
    logic             valid_nxt, err_nxt;
    logic [5:0]       cand, scan_idx;
    logic [63:0]      mask_pad;
    logic             cand_ok;

    assign lfsr_step = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    assign cand      = lfsr[5:0];
    // Indices 54..63 are padded as "used" so out-of-range candidates reject.
    assign mask_pad  = {10'h3FF, used_mask};
    assign cand_ok   = !mask_pad[cand];

    always_comb begin
        scan_idx = 6'd0;
        for (int i = 53; i >= 0; i--) begin
            if (!used_mask[i]) scan_idx = 6'(i);
        end
    end

    always_comb begin
        state_nxt = state;
        lfsr_nxt  = lfsr_step;
        tries_nxt = tries;
        mask_nxt  = used_mask;
        left_nxt  = cards_left;
        idx_nxt   = card_idx;
        valid_nxt = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (deck_clear) begin
                    mask_nxt = '0;
                    left_nxt = 6'd54;
                end
                if (seed_load) lfsr_nxt = (seed_in == 16'h0000) ? SEED : seed_in;
                if (draw_req) begin
                    if (deck_empty && !deck_clear) begin
                        err_nxt = 1'b1;
                    end else begin
                        state_nxt = SEARCH;
                        tries_nxt = '0;
                    end
                end
            end
            SEARCH: begin
                if (cand_ok) begin
                    idx_nxt   = cand;
                    mask_nxt  = used_mask | (54'd1 << cand);
                    left_nxt  = cards_left - 6'd1;
                    valid_nxt = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    tries_nxt = tries + 1'b1;
                    if (tries == TRY_W'(MAX_TRIES - 1)) state_nxt = SCAN;
                end
            end
            SCAN: begin
                idx_nxt   = scan_idx;
                mask_nxt  = used_mask | (54'd1 << scan_idx);
                left_nxt  = cards_left - 6'd1;
                valid_nxt = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            lfsr       <= SEED;
            tries      <= '0;
            used_mask  <= '0;
            cards_left <= 6'd54;
            card_idx   <= 6'd0;
            card_valid <= 1'b0;
            deck_empty <= 1'b0;
            draw_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            lfsr       <= lfsr_nxt;
            tries      <= tries_nxt;
            used_mask  <= mask_nxt;
            cards_left <= left_nxt;
            card_idx   <= idx_nxt;
            card_valid <= valid_nxt;
            deck_empty <= (left_nxt == 6'd0);
            draw_err   <= err_nxt;
        end
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: doc/card_picker.md
# card_picker

Upstream random-draw stage for the card game. Holds a 16-bit Galois LFSR and a 54-entry "used" mask, and on each draw request returns one card index in 0..53 that has not yet been dealt, with a one-cycle valid pulse. `card_game` consumes this stream to build its `dealt_cards` view. A bounded rejection search guarantees every request completes in a fixed maximum time.

## Interface
- `SEED`, 16'hACE1: LFSR value after reset; also substituted when a zero seed is loaded.
- `MAX_TRIES`, 64: rejected random candidates allowed before falling back to a linear scan.
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `draw_req`  in  1  request one card; sampled only in IDLE.
- `seed_load`  in  1  load `seed_in` into the LFSR; honoured only in IDLE.
- `seed_in`  in  16  seed value.
- `deck_clear`  in  1  clear the used mask (new deck); honoured only in IDLE.
- `card_idx`  out  6  last dealt card index; held until the next `card_valid`.
- `card_valid`  out  1  one-cycle pulse when `card_idx` updates.
- `busy`  out  1  high in SEARCH and SCAN.
- `deck_empty`  out  1  high when all 54 cards are used.
- `cards_left`  out  6  unused card count, 0..54.
- `used_mask`  out  54  bit i set when card i has been dealt.
- `draw_err`  out  1  one-cycle pulse when a draw is requested on an empty deck.

## Operation
- **Reset** (`reset`=0 at a clock edge):
  - LFSR = `SEED`, state = IDLE.
  - `used_mask` = 0, `cards_left` = 54, `card_idx` = 0.
  - `card_valid`, `busy`, `deck_empty`, `draw_err` = 0.
  - Reset overrides every other input and every state.
- **LFSR:** 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400). Advances every cycle out of reset, in every state. Being free-running, the draw outcome depends on request timing.
- **Seed load:** `seed_load` in IDLE loads `seed_in`; a zero `seed_in` loads `SEED` instead. The LFSR is therefore never zero.
- **Deck clear:** `deck_clear` in IDLE sets `used_mask` = 0 and `cards_left` = 54. Priority order in IDLE: `deck_clear`, then `seed_load`, then `draw_req`; all three may act in the same cycle.
- **States:**
  - **IDLE:**
    - `draw_req` with `deck_empty`=0: go to SEARCH, try counter = 0.
    - `draw_req` with `deck_empty`=1: pulse `draw_err` next cycle and stay in IDLE.
  - **SEARCH:** candidate c = current LFSR[5:0].
    - If c<54 and `used_mask`[c]=0: accept.
    - Otherwise increment the try counter. When it reaches `MAX_TRIES`, go to SCAN.
  - **SCAN:** priority-encode the lowest index with `used_mask` bit clear, and accept it. The deck is non-empty by construction, so an index always exists.
  - **Accept (same edge):**
    - `card_idx` = c.
    - Set `used_mask`[c].
    - `cards_left` decrements by 1.
    - `card_valid` = 1 for one cycle.
    - State returns to IDLE.
- `deck_empty` = (`cards_left`==0), registered and updated with `cards_left`.
- `draw_req`, `seed_load` and `deck_clear` are ignored while `busy`=1; the requester must hold or re-issue after `busy` falls.

## Timing
- `draw_req` sampled high in IDLE at edge N:
  - `busy`=1 from N+1.
  - First candidate evaluated during cycle N+1.
- Minimum latency: `card_valid` high in cycle N+2, with `busy`=0 in that same cycle.
- Maximum latency: `MAX_TRIES` rejections (cycles N+1..N+64), SCAN in cycle N+65, `card_valid` in cycle N+66.
- A new `draw_req` is accepted in the cycle `card_valid` is high, since the block is in IDLE then. Back-to-back draws therefore sustain one card per 2 cycles at best.
- `draw_err`: high exactly in cycle N+1 for an empty-deck request at edge N. No state change, and `card_idx` is unchanged.
- `used_mask`, `cards_left` and `deck_empty` update on the same edge that raises `card_valid`.
- `reset` low mid-SEARCH or mid-SCAN aborts the draw: no `card_valid`, and all outputs take their reset values on that edge.

## Test plan
- **Reset:** hold `reset`=0 for 2 cycles, then release → `cards_left`=54, `used_mask`=0, `card_idx`=0, and `busy`, `card_valid`, `deck_empty`, `draw_err` all 0.
- **Single draw:** `seed_load` with 16'h0001, then one `draw_req` → exactly one `card_valid` within cycles N+2..N+66, `card_idx`<54, that `used_mask` bit set, `cards_left`=53.
- **Full deck:** 54 sequential draws → 54 distinct indices, `used_mask`=all ones, `deck_empty`=1 after the 54th. A 55th `draw_req` → `draw_err` pulse at N+1, no `card_valid`, `card_idx` unchanged.
- **Determinism and zero seed:** run the same seed with identical draw timing twice → identical index sequence. `seed_in`=0 → sequence identical to loading 16'hACE1.
- **Reset mid-SEARCH:** assert `reset`=0 one cycle after `draw_req` → no `card_valid`, `used_mask`=0, `cards_left`=54, and the next draw behaves as after the initial reset.
- **Deck clear:**
  - `deck_clear` after 10 draws → `cards_left`=54, `used_mask`=0.
  - `deck_clear` pulsed while `busy`=1 → ignored; `cards_left` decrements normally.
